// File: rtl/gray_addsub_seq.sv
// ============================================================================
// Module   : gray_addsub_seq
// Brief    : Multi-cycle chunked adder/subtractor with binary and Gray result.
//            Define GRAY_ADDSUB_OVF_EN to add the signed-overflow output ovf.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_addsub_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   result,
    output logic [WIDTH:0]   gray,
`ifdef GRAY_ADDSUB_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int c_NSLICE = WIDTH / CHUNK;
    localparam int c_CNT_W  = (c_NSLICE > 1) ? $clog2(c_NSLICE) : 1;
    localparam int c_BASE_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_param_check
            $error("gray_addsub_seq: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_carry;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [WIDTH:0]       r_result;
    logic [WIDTH:0]       r_gray;

    logic [c_BASE_W-1:0]  w_base;
    logic [CHUNK-1:0]     w_slice_a;
    logic [CHUNK-1:0]     w_slice_b;
    logic [CHUNK:0]       w_sum;
    logic                 w_last;
    logic [WIDTH-1:0]     w_res_lo;
    logic [WIDTH:0]       w_res_next;

    // ------------------------------------------------------------------------
    // Slice datapath: one CHUNK-wide add per clock through the registered carry
    // ------------------------------------------------------------------------
    assign w_base    = c_BASE_W'(r_cnt) * c_BASE_W'(CHUNK);
    assign w_slice_a = r_a[w_base +: CHUNK];
    assign w_slice_b = r_b[w_base +: CHUNK];
    assign w_sum     = {1'b0, w_slice_a} + {1'b0, w_slice_b} + (CHUNK+1)'(r_carry);
    assign w_last    = (r_cnt == c_CNT_W'(c_NSLICE - 1));

    always_comb begin
        w_res_lo                  = r_result[WIDTH-1:0];
        w_res_lo[w_base +: CHUNK] = w_sum[CHUNK-1:0];
    end

    // The carry-out only lands in the MSB on the final slice.
    assign w_res_next = {(w_last ? w_sum[CHUNK] : r_result[WIDTH]), w_res_lo};

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_next = S_RUN;
            S_RUN:   if (w_last)    w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Operand latch and result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_gray   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        // Subtract is A + ~B + 1: invert B here, seed the carry with mode.
                        r_a     <= a;
                        r_b     <= mode ? ~b : b;
                        r_carry <= mode;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_result <= w_res_next;
                    r_carry  <= w_sum[CHUNK];
                    r_cnt    <= r_cnt + c_CNT_W'(1);
                    if (w_last) begin
                        r_gray <= w_res_next ^ (w_res_next >> 1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef GRAY_ADDSUB_OVF_EN
    logic r_ovf;
    logic w_carry_into_msb;

    // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
    assign w_carry_into_msb = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_sum[CHUNK-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if ((r_state == S_RUN) && w_last) begin
            r_ovf <= w_carry_into_msb ^ w_sum[CHUNK];
        end
    end

    assign ovf = r_ovf;
`endif

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state == S_RUN);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign gray      = r_gray;

endmodule

`default_nettype wire

// File: doc/gray_addsub_seq.md
Name: gray_addsub_seq

Overview:
- Multi-cycle parametrised adder/subtractor with Gray-coded result. Successor to the 8-bit combinational add/sub-to-Gray unit.
- Operands are latched on a valid/ready handshake. They are added or subtracted CHUNK bits per clock, least significant chunk first, through a registered carry.
- The result is presented in binary and in Gray code, held under an output valid/ready handshake.
- Sits between the lab operand-entry logic (switches/registers) and the display/LED stage.

Parameters:
- WIDTH, 8, operand width in bits; result width is WIDTH+1.
- CHUNK, 2, bits processed per clock; WIDTH % CHUNK must be 0 (elaboration error otherwise).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands/mode valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- mode  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH+1  binary result; MSB = carry out (for subtract: 1 = no borrow).
- gray  output  WIDTH+1  Gray code of result: result ^ (result >> 1).
- busy  output  1  high in RUN.

Behaviour:
- Reset (async, immediate): state = IDLE. Outputs: in_ready=1, out_valid=0, busy=0, result=0, gray=0. Internal carry, chunk counter and operand registers are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at a rising edge: latch a, b and mode, go to RUN.
  - Latching inverts b when mode=1. The initial carry is set to mode (two's-complement subtract: A + ~B + 1).
  - The counter is cleared.
- RUN:
  - in_ready=0, busy=1. Each edge processes one CHUNK slice, LSB slice first, using the registered carry.
  - The sum slice is written into the result register and the carry is updated.
  - After slice N-1 (N = WIDTH/CHUNK), the final carry goes to result[WIDTH]. gray is computed from the complete result in the same edge, and the FSM goes to DONE.
  - Input changes during RUN are ignored.
- DONE:
  - out_valid=1. result and gray are stable.
  - On out_ready=1 at an edge: go to IDLE, out_valid deasserts.
  - in_ready stays 0 in DONE; there is no same-cycle accept. The back-to-back issue interval is N+2 cycles.
- Latency: operands accepted at edge k; out_valid high after edge k+N (N=4 at defaults).
- result and gray are only guaranteed meaningful while out_valid=1. During RUN, result holds partial slices and gray holds its previous value.
- Arithmetic:
  - Unsigned, modulo 2^(WIDTH+1).
  - Subtract with A<B gives result[WIDTH]=0 and two's-complement low bits. Example: 0x05-0x06 gives result=0x0FF.
- out_ready held high before DONE has no effect.
- in_valid held high continuously: a new accept occurs on each IDLE cycle.
- rst asserted mid-RUN or mid-DONE: the operation is aborted, all reset values apply, and no out_valid pulse is produced.

Optional Feature:
- Macro: GRAY_ADDSUB_OVF_EN.
- Defined:
  - Adds port ovf (output, 1): signed two's-complement overflow of the WIDTH-bit operation.
  - ovf = (carry into MSB) ^ (carry out of MSB), registered with the last slice.
  - ovf is valid with out_valid and reset to 0.
- Undefined: port ovf and its logic are absent; everything else is identical.

Test Plan:
- WIDTH=8, CHUNK=2, mode=0, a=0x80, b=0x01, out_ready=1 → out_valid 4 cycles after accept; result=0x081, gray=0x0C1.
- mode=1, a=0x94, b=0x05 → result=0x18F, gray=0x148. Then mode=1, a=0x20, b=0x11 → result=0x10F, gray=0x188.
- mode=1, a=0x05, b=0x06 → result=0x0FF, gray=0x080. Hold out_ready=0 for 5 cycles: out_valid and outputs stay stable and in_ready=0. Raise out_ready: IDLE on the next edge.
- Change a/b every cycle during RUN → result reflects only the operands latched at accept.
- Assert rst 2 cycles into RUN → all outputs 0 immediately, in_ready=1. A fresh a=0x01, b=0x01 add → result=0x002, gray=0x003.
- With GRAY_ADDSUB_OVF_EN defined:
  - add a=0x7F, b=0x01 → result=0x080, gray=0x0C0, ovf=1.
  - subtract a=0x20, b=0x11 → ovf=0.
  - Repeat all above at WIDTH=12, CHUNK=3 and WIDTH=8, CHUNK=8 (latency 1).
